lane_encoder: RTL and testbench
===============================

LANE_ENCODER -- requirements
Module: lane_encoder

Interface
REQ-001 The module SHALL have a parameter SCRAMBLE, default 1, which enables the payload scrambler when 1 and passes the payload through when 0.
REQ-002 The module SHALL have a parameter SCR_SEED, default 58'h3FF_FFFF_FFFF_FFFF, which is the scrambler state loaded at reset.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port valid_in, input, 1 bit: a 64-bit block from the lane controller is present this cycle.
REQ-006 The module SHALL have port ctrl_in, input, 1 bit: 1 means a control block, 0 means a data block.
REQ-007 The module SHALL have port data_in, input, 64 bits (ENCODER_DATA_IN_SIZE): the block payload; bit 0 is transmitted first.
REQ-008 The module SHALL have port valid_out, output, 1 bit: data_out holds a new 66-bit block.
REQ-009 The module SHALL have port data_out, output, 66 bits: [1:0] is the sync header and [65:2] is the payload.
REQ-010 The module SHALL have port blk_cnt, output, 16 bits: the count of blocks emitted since reset.

Function
REQ-011 The module SHALL register the encoded block one clk after valid_in is sampled high, giving a latency of exactly 1 cycle.
REQ-012 For ctrl_in=0, the sync header data_out[1:0] SHALL be 2'b01.
REQ-013 For ctrl_in=1, the sync header data_out[1:0] SHALL be 2'b10.
REQ-014 The sync header SHALL never be scrambled.
REQ-015 The scrambler SHALL be self-synchronous with polynomial G(x)=1+x^39+x^58 and a 58-bit state S[57:0], where S[0] is the most recent output bit.
REQ-016 The scrambler SHALL process bits i=0..63 in order, computing o[i]=data_in[i]^S[38]^S[57], then updating S={S[56:0],o[i]}; all 64 steps SHALL complete combinationally within one cycle.
REQ-017 data_out[65:2] SHALL equal o[63:0] when SCRAMBLE=1, and data_in when SCRAMBLE=0.
REQ-018 Control blocks SHALL be scrambled identically to data blocks.
REQ-019 The S register SHALL update only in a cycle where valid_in=1.
REQ-020 In a cycle where valid_in=0: valid_out SHALL be 0 next cycle, data_out SHALL hold its last value, and S and blk_cnt SHALL hold.
REQ-021 valid_out SHALL be a single-cycle pulse per accepted block; back-to-back valid_in SHALL produce back-to-back valid_out with no bubbles.
REQ-022 blk_cnt SHALL increment by 1 with each valid_out pulse, updated in the same cycle valid_out asserts.
REQ-023 blk_cnt SHALL wrap from 16'hFFFF to 16'h0000 without any flag.
REQ-024 When SCRAMBLE=0, the S register SHALL still be present but SHALL remain constant at SCR_SEED.

Reset
REQ-025 While rst=1 at a clk edge: valid_out SHALL be 0, data_out SHALL be 66'h0, blk_cnt SHALL be 16'h0, and S SHALL be SCR_SEED.
REQ-026 Reset SHALL take priority over valid_in in the same cycle, and a block presented during that cycle SHALL be dropped.
REQ-027 A reset asserted mid-stream SHALL discard the in-flight block, so no valid_out follows the reset cycle.
REQ-028 The first block accepted after reset deasserts SHALL be scrambled from SCR_SEED.
REQ-029 valid_in=1 in the first cycle after rst deasserts SHALL be accepted.

Verification
REQ-030 Reset check: hold rst for 2 cycles with valid_in=1 -> valid_out=0, data_out=0 and blk_cnt=0 throughout, and no output appears for the dropped blocks.
REQ-031 Bypass check: with SCRAMBLE=0, present ctrl_in=0 and data_in=64'hDEADB00D_00000000 -> next cycle valid_out=1 and data_out={64'hDEADB00D_00000000,2'b01}, with blk_cnt=1.
REQ-032 Scrambled zeros: with SCRAMBLE=1 and default seed, present one data block of data_in=0 after reset -> data_out={64'h03FF_FF80_0000_0000,2'b01}.
REQ-033 Control header and gaps: send a control block, then 3 idle cycles, then a data block -> headers 2'b10 then 2'b01, valid_out low for exactly 3 cycles, data_out held during the gap, and the second payload equals a reference model run with no gap.
REQ-034 Descrambler round-trip: stream 7 back-to-back blocks {32'hDEADB00D,j} for j=0..6 with an idle gap after j=1 -> a bench descrambler (o^S38^S57 over received bits) recovers every payload, and blk_cnt ends at 7.
REQ-035 Counter wrap and mid-stream reset: preload by streaming 65535 blocks, then one more -> blk_cnt goes 16'hFFFF to 16'h0000; then assert rst mid-burst -> the next accepted block's payload matches the seed-based expected value.

Source files
------------

// File: rtl/lane_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : lane_encoder                                                      |
// | 64b/66b block encoder: sync header plus optional self-synchronous          |
// | 1+x^39+x^58 payload scrambler, one-cycle latency, block counter.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module lane_encoder #(
  parameter int          SCRAMBLE = 1,
  parameter logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        ctrl_in,
  input  logic [63:0] data_in,
  output logic        valid_out,
  output logic [65:0] data_out,
  output logic [15:0] blk_cnt
);

  localparam int         ENCODER_DATA_IN_SIZE = 64;
  localparam logic [1:0] c_SH_DATA = 2'b01;
  localparam logic [1:0] c_SH_CTRL = 2'b10;

  logic [57:0] r_scr;
  logic        r_valid;
  logic [65:0] r_data;
  logic [15:0] r_cnt;

  logic [57:0] w_scr_nxt;
  logic [63:0] w_scr_out;
  logic [57:0] w_scr_load;
  logic [63:0] w_payload;
  logic [1:0]  w_sync;

  // Bit-serial scrambler unrolled across the whole block; bit 0 goes first.
  always_comb begin
    logic [57:0] s;
    logic [63:0] o;
    s = r_scr;
    o = '0;
    for (int i = 0; i < ENCODER_DATA_IN_SIZE; i++) begin
      o[i] = data_in[i] ^ s[38] ^ s[57];
      s    = {s[56:0], o[i]};
    end
    w_scr_nxt = s;
    w_scr_out = o;
  end

  generate
    if (SCRAMBLE != 0) begin : g_scr
      assign w_payload  = w_scr_out;
      assign w_scr_load = w_scr_nxt;
    end else begin : g_byp
      assign w_payload  = data_in;
      assign w_scr_load = SCR_SEED;
    end
  endgenerate

  assign w_sync = ctrl_in ? c_SH_CTRL : c_SH_DATA;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_scr   <= SCR_SEED;
    end else begin
      r_valid <= valid_in;
      if (valid_in) begin
        r_data <= {w_payload, w_sync};
        r_cnt  <= r_cnt + 16'd1;
        r_scr  <= w_scr_load;
      end
    end
  end

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign blk_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lane_encoder.sv
`default_nettype none
// Directed bench for lane_encoder: a scrambling instance and a bypass instance
// share clock, reset and control; each has its own payload input.
module tb_lane_encoder;

  localparam logic [57:0] c_SEED  = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_ZSCR  = 64'h03FF_FF80_0000_0000;
  localparam logic [63:0] c_BYPD  = 64'hDEADB00D_00000000;

  logic        clk = 1'b0;
  logic        rst, valid_in, ctrl_in;
  logic [63:0] d_scr, d_byp;
  logic        vo_s, vo_b;
  logic [65:0] do_s, do_b;
  logic [15:0] cnt_s, cnt_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lane_encoder #(.SCRAMBLE(1), .SCR_SEED(c_SEED)) u_scr (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(d_scr), .valid_out(vo_s), .data_out(do_s), .blk_cnt(cnt_s));

  lane_encoder #(.SCRAMBLE(0), .SCR_SEED(c_SEED)) u_byp (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(d_byp), .valid_out(vo_b), .data_out(do_b), .blk_cnt(cnt_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Forward scrambler reference: returns {next_state, scrambled_payload}.
  function automatic logic [121:0] scr_ref(input logic [63:0] d, input logic [57:0] s_in);
    logic [57:0] s;
    logic [63:0] o;
    s = s_in;
    for (int i = 0; i < 64; i++) begin
      o[i] = d[i] ^ s[38] ^ s[57];
      s    = {s[56:0], o[i]};
    end
    return {s, o};
  endfunction

  // Receiver-side descrambler: state is fed from received (scrambled) bits.
  function automatic logic [121:0] descr(input logic [63:0] r, input logic [57:0] s_in);
    logic [57:0] s;
    logic [63:0] d;
    s = s_in;
    for (int i = 0; i < 64; i++) begin
      d[i] = r[i] ^ s[38] ^ s[57];
      s    = {s[56:0], r[i]};
    end
    return {s, d};
  endfunction

  initial begin
    logic [57:0]  m_s;
    logic [57:0]  ds;
    logic [121:0] res;
    logic [65:0]  held;
    logic [63:0]  blk;

    rst      = 1'b1;
    valid_in = 1'b1;
    ctrl_in  = 1'b0;
    d_scr    = 64'h1111_2222_3333_4444;
    d_byp    = 64'h5555_6666_7777_8888;

    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_valid", {65'd0, vo_s}, 66'd0);
      chk("rst_data",  do_s, 66'd0);
      chk("rst_cnt",   {50'd0, cnt_s}, 66'd0);
    end

    rst      = 1'b0;
    valid_in = 1'b0;
    tick();
    chk("drop_valid", {65'd0, vo_s}, 66'd0);
    chk("drop_cnt",   {50'd0, cnt_s}, 66'd0);

    // First block after reset: zeros through the scrambler, bypass pattern.
    valid_in = 1'b1;
    d_scr    = 64'd0;
    d_byp    = c_BYPD;
    tick();
    chk("zero_valid", {65'd0, vo_s}, 66'd1);
    chk("zero_data",  do_s, {c_ZSCR, 2'b01});
    chk("byp_valid",  {65'd0, vo_b}, 66'd1);
    chk("byp_data",   do_b, {c_BYPD, 2'b01});
    chk("byp_cnt",    {50'd0, cnt_b}, 66'd1);
    res = scr_ref(64'd0, c_SEED);
    m_s = res[121:64];

    // Control block, three idle cycles, then data block.
    ctrl_in = 1'b1;
    d_scr   = 64'h0123_4567_89AB_CDEF;
    tick();
    res  = scr_ref(64'h0123_4567_89AB_CDEF, m_s);
    m_s  = res[121:64];
    held = {res[63:0], 2'b10};
    chk("ctrl_data", do_s, held);
    chk("ctrl_cnt",  {50'd0, cnt_s}, 66'd2);

    valid_in = 1'b0;
    ctrl_in  = 1'b0;
    d_scr    = 64'hA5A5_A5A5_A5A5_A5A5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gap_valid", {65'd0, vo_s}, 66'd0);
      chk("gap_hold",  do_s, held);
      chk("gap_cnt",   {50'd0, cnt_s}, 66'd2);
    end

    valid_in = 1'b1;
    d_scr    = 64'hFEDC_BA98_7654_3210;
    tick();
    res = scr_ref(64'hFEDC_BA98_7654_3210, m_s);
    m_s = res[121:64];
    chk("post_gap_valid", {65'd0, vo_s}, 66'd1);
    chk("post_gap_data",  do_s, {res[63:0], 2'b01});
    chk("post_gap_cnt",   {50'd0, cnt_s}, 66'd3);

    valid_in = 1'b0;
    tick();
    chk("pulse_end", {65'd0, vo_s}, 66'd0);

    // Descrambler round trip from a fresh reset, with a gap after j=1.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    valid_in = 1'b1;
    ds       = c_SEED;
    for (int j = 0; j < 7; j++) begin
      blk   = {32'hDEADB00D, j[31:0]};
      d_scr = blk;
      tick();
      chk("rt_valid",  {65'd0, vo_s}, 66'd1);
      chk("rt_header", {64'd0, do_s[1:0]}, 66'd1);
      res = descr(do_s[65:2], ds);
      ds  = res[121:64];
      chk("rt_payload", {2'b00, res[63:0]}, {2'b00, blk});
      if (j == 1) begin
        valid_in = 1'b0;
        tick();
        chk("rt_gap", {65'd0, vo_s}, 66'd0);
        valid_in = 1'b1;
      end
    end
    valid_in = 1'b0;
    tick();
    chk("rt_cnt", {50'd0, cnt_s}, 66'd7);

    // Counter wrap.
    valid_in = 1'b1;
    d_scr    = 64'd0;
    d_byp    = 64'd0;
    repeat (65535 - 7) tick();
    chk("cnt_ffff", {50'd0, cnt_s}, 66'h0FFFF);
    tick();
    chk("cnt_wrap", {50'd0, cnt_s}, 66'd0);
    chk("wrap_valid", {65'd0, vo_s}, 66'd1);

    // Reset in the middle of a burst.
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {65'd0, vo_s}, 66'd0);
    chk("mid_rst_data",  do_s, 66'd0);
    chk("mid_rst_cnt",   {50'd0, cnt_s}, 66'd0);
    rst = 1'b0;
    tick();
    chk("after_rst_valid", {65'd0, vo_s}, 66'd1);
    chk("after_rst_data",  do_s, {c_ZSCR, 2'b01});
    chk("after_rst_cnt",   {50'd0, cnt_s}, 66'd1);
    chk("after_rst_byp",   do_b, {64'd0, 2'b01});
    valid_in = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
